// File: rtl/controle_estoque_rolhas_pkg.sv
// Shared constants, count widths and FSM encoding for the cork supply controller.
package controle_estoque_pkg;

  localparam int CNT_W = 5;
  localparam int STK_W = 4;
  localparam int TMR_W = 8;

  localparam int MAG_MAX_DEF     = 20;
  localparam int MAG_LOW_DEF     = 5;
  localparam int REFILL_QTY_DEF  = 12;
  localparam int STOCK_MAX_DEF   = 15;
  localparam int STOCK_INIT_DEF  = 15;
  localparam int DISP_CYCLES_DEF = 4;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DISPENSE = 2'd1,
    S_SETTLE   = 2'd2,
    S_ALARM    = 2'd3
  } state_t;

endpackage

// File: rtl/controle_estoque_rolhas_if.sv
// Request/status bundle between the bottling line and the cork supply controller.
interface controle_estoque_rolhas_if;
  import controle_estoque_pkg::*;

  logic             enable;
  logic             dec;
  logic             add_manual;
  logic [CNT_W-1:0] contagem;
  logic [STK_W-1:0] estoque;
  logic             disp_acionado;
  logic             LED_Alarme;
  logic             rolha_disponivel;
  logic             erro_dec;

  modport master (
    output enable, dec, add_manual,
    input  contagem, estoque, disp_acionado, LED_Alarme, rolha_disponivel, erro_dec
  );

  modport slave (
    input  enable, dec, add_manual,
    output contagem, estoque, disp_acionado, LED_Alarme, rolha_disponivel, erro_dec
  );

endinterface

// File: rtl/controle_estoque_rolhas_temporizador.sv
// Loadable down-counter timing the dispenser actuation window; holds at zero.
module temporizador_dispensador
  import controle_estoque_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [TMR_W-1:0] value,
  output logic             zero
);

  logic [TMR_W-1:0] timer;

  always_ff @(posedge clk) begin
    if (rst) begin
      timer <= '0;
    end else if (load) begin
      timer <= value;
    end else if (timer != '0) begin
      timer <= timer - 1'b1;
    end
  end

  assign zero = (timer == '0);

endmodule

// File: rtl/controle_estoque_rolhas.sv
// Cork supply controller: magazine/stock counters, timed refill FSM and
// same-edge arbitration of sealing decrement, manual addition and refill transfer.
module controle_estoque_rolhas
  import controle_estoque_pkg::*;
#(
  parameter int MAG_MAX     = MAG_MAX_DEF,
  parameter int MAG_LOW     = MAG_LOW_DEF,
  parameter int REFILL_QTY  = REFILL_QTY_DEF,
  parameter int STOCK_MAX   = STOCK_MAX_DEF,
  parameter int STOCK_INIT  = STOCK_INIT_DEF,
  parameter int DISP_CYCLES = DISP_CYCLES_DEF
)
(
  input  logic                        clk,
  input  logic                        reset,
  controle_estoque_rolhas_if.slave    bus
);

  localparam logic [5:0]       MAG_MAX6    = 6'(MAG_MAX);
  localparam logic [5:0]       MAG_LOW6    = 6'(MAG_LOW);
  localparam logic [5:0]       QTY6        = 6'(REFILL_QTY);
  localparam logic [5:0]       STOCK_MAX6  = 6'(STOCK_MAX);
  localparam logic [STK_W-1:0] STOCK_RST   = STK_W'(STOCK_INIT);
  localparam logic [TMR_W-1:0] TMR_LOAD    = TMR_W'(DISP_CYCLES - 1);

  function automatic logic [5:0] min3(input logic [5:0] a,
                                      input logic [5:0] b,
                                      input logic [5:0] c);
    logic [5:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  state_t           state;
  logic [CNT_W-1:0] contagem;
  logic [STK_W-1:0] estoque;
  logic             disp_acionado;
  logic             led_alarme;
  logic             erro_dec;

  logic             tmr_load;
  logic             tmr_zero;

  logic             dec_eff;
  logic             add_eff;
  logic             transfer;
  logic             mag_low;
  logic             start_refill;
  logic [5:0]       cont_w;
  logic [5:0]       est_w;
  logic [5:0]       room;
  logic [5:0]       k;
  logic [5:0]       est_after_k;
  logic [5:0]       cont_next_w;
  logic [5:0]       est_next_w;

  // All arithmetic in 6 bits so MAG_MAX - contagem and stock - k cannot underflow.
  always_comb begin
    cont_w       = {1'b0, contagem};
    est_w        = {2'b0, estoque};
    dec_eff      = bus.dec && (contagem != '0);
    transfer     = (state == S_DISPENSE) && tmr_zero;
    mag_low      = (cont_w <= MAG_LOW6);
    start_refill = (state == S_IDLE) && bus.enable && mag_low && (estoque != '0);
    room         = MAG_MAX6 - (cont_w - {5'b0, dec_eff});
    k            = transfer ? min3(QTY6, est_w, room) : 6'd0;
    cont_next_w  = cont_w - {5'b0, dec_eff} + k;
    est_after_k  = est_w - k;
    add_eff      = bus.add_manual && (est_after_k < STOCK_MAX6);
    est_next_w   = est_after_k + {5'b0, add_eff};
    tmr_load     = start_refill;
  end

  temporizador_dispensador u_temporizador (
    .clk   (clk),
    .rst   (reset),
    .load  (tmr_load),
    .value (TMR_LOAD),
    .zero  (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      contagem      <= '0;
      estoque       <= STOCK_RST;
      disp_acionado <= 1'b0;
      led_alarme    <= 1'b0;
      erro_dec      <= 1'b0;
    end else begin
      contagem <= CNT_W'(cont_next_w);
      estoque  <= STK_W'(est_next_w);
      erro_dec <= bus.dec && (contagem == '0);
      case (state)
        S_IDLE: begin
          if (start_refill) begin
            state         <= S_DISPENSE;
            disp_acionado <= 1'b1;
          end else if (mag_low && (estoque == '0)) begin
            state      <= S_ALARM;
            led_alarme <= 1'b1;
          end
        end
        // Enable is not looked at here: a started refill always completes.
        S_DISPENSE: begin
          if (tmr_zero) begin
            state         <= S_SETTLE;
            disp_acionado <= 1'b0;
          end
        end
        S_SETTLE: begin
          state <= S_IDLE;
        end
        S_ALARM: begin
          if (estoque != '0) begin
            state      <= S_IDLE;
            led_alarme <= 1'b0;
          end
        end
        default: begin
          state         <= S_IDLE;
          disp_acionado <= 1'b0;
          led_alarme    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.contagem         = contagem;
  assign bus.estoque          = estoque;
  assign bus.disp_acionado    = disp_acionado;
  assign bus.LED_Alarme       = led_alarme;
  assign bus.erro_dec         = erro_dec;
  assign bus.rolha_disponivel = (contagem != '0);

endmodule

// File: tb/tb_controle_estoque_rolhas.sv
// Bench for the cork supply controller: directed scenarios plus random traffic
// against a cycle-level behavioural model of magazine, stock and refill timing.
module tb_controle_estoque_rolhas;

  localparam int MAG_MAX     = 20;
  localparam int MAG_LOW     = 5;
  localparam int REFILL_QTY  = 12;
  localparam int STOCK_MAX   = 15;
  localparam int STOCK_INIT  = 15;
  localparam int DISP_CYCLES = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  controle_estoque_rolhas_if bus ();

  controle_estoque_rolhas dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: corks in magazine/stock, remaining dispense cycles, settle gap, alarm.
  int m_mag, m_stk, m_busy;
  bit m_settle, m_alarm, m_err;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_update(input bit en, input bit d, input bit a, input bit r);
    int de, k, ae;
    if (r) begin
      m_mag = 0; m_stk = STOCK_INIT; m_busy = 0;
      m_settle = 0; m_alarm = 0; m_err = 0;
    end else begin
      de    = (d && m_mag > 0) ? 1 : 0;
      m_err = d && (m_mag == 0);
      k     = 0;
      if (m_busy > 0) begin
        if (m_busy == 1) begin
          k = imin(imin(REFILL_QTY, m_stk), MAG_MAX - (m_mag - de));
          m_settle = 1;
        end
        m_busy--;
      end else if (m_settle) begin
        m_settle = 0;
      end else if (m_alarm) begin
        if (m_stk != 0) m_alarm = 0;
      end else if (m_mag <= MAG_LOW) begin
        if (en && m_stk != 0) m_busy = DISP_CYCLES;
        else if (m_stk == 0)  m_alarm = 1;
      end
      m_mag = m_mag - de + k;
      ae    = (a && (m_stk - k) < STOCK_MAX) ? 1 : 0;
      m_stk = m_stk - k + ae;
    end
  endtask

  task automatic step(input bit en, input bit d, input bit a, input bit r);
    bus.enable     = en;
    bus.dec        = d;
    bus.add_manual = a;
    reset          = r;
    @(posedge clk);
    model_update(en, d, a, r);
    #1;
  endtask

  task automatic test_reset();
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    checks++; if (bus.contagem !== 5'd0) begin errors++; $display("FAIL reset_contagem got %0d want 0", bus.contagem); end
    checks++; if (bus.estoque !== 4'd15) begin errors++; $display("FAIL reset_estoque got %0d want 15", bus.estoque); end
    checks++; if (bus.disp_acionado !== 1'b0) begin errors++; $display("FAIL reset_disp got %b want 0", bus.disp_acionado); end
    checks++; if (bus.LED_Alarme !== 1'b0) begin errors++; $display("FAIL reset_led got %b want 0", bus.LED_Alarme); end
    checks++; if (bus.erro_dec !== 1'b0) begin errors++; $display("FAIL reset_erro got %b want 0", bus.erro_dec); end
    checks++; if (bus.rolha_disponivel !== 1'b0) begin errors++; $display("FAIL reset_rolha got %b want 0", bus.rolha_disponivel); end
  endtask

  task automatic test_first_refill();
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 0);
      checks++; if (bus.disp_acionado !== 1'b1) begin errors++; $display("FAIL refill1_disp_on cyc=%0d got %b want 1", i, bus.disp_acionado); end
    end
    step(1, 0, 0, 0);
    checks++; if (bus.contagem !== 5'd12) begin errors++; $display("FAIL refill1_contagem got %0d want 12", bus.contagem); end
    checks++; if (bus.estoque !== 4'd3) begin errors++; $display("FAIL refill1_estoque got %0d want 3", bus.estoque); end
    checks++; if (bus.rolha_disponivel !== 1'b1) begin errors++; $display("FAIL refill1_rolha got %b want 1", bus.rolha_disponivel); end
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 0);
      checks++; if (bus.disp_acionado !== 1'b0) begin errors++; $display("FAIL refill1_no_retrigger cyc=%0d got %b want 0", i, bus.disp_acionado); end
    end
  endtask

  task automatic test_partial_refill();
    for (int i = 0; i < 7; i++) step(1, 1, 0, 0);
    checks++; if (bus.contagem !== 5'd5) begin errors++; $display("FAIL partial_pre_contagem got %0d want 5", bus.contagem); end
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
    checks++; if (bus.contagem !== 5'd8) begin errors++; $display("FAIL partial_contagem got %0d want 8", bus.contagem); end
    checks++; if (bus.estoque !== 4'd0) begin errors++; $display("FAIL partial_estoque got %0d want 0", bus.estoque); end
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
  endtask

  task automatic test_alarm();
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    checks++; if (bus.LED_Alarme !== 1'b1) begin errors++; $display("FAIL alarm_on got %b want 1", bus.LED_Alarme); end
    step(1, 0, 1, 0);
    checks++; if (bus.estoque !== 4'd1) begin errors++; $display("FAIL alarm_add_estoque got %0d want 1", bus.estoque); end
    checks++; if (bus.LED_Alarme !== 1'b1) begin errors++; $display("FAIL alarm_still_on got %b want 1", bus.LED_Alarme); end
    step(1, 0, 0, 0);
    checks++; if (bus.LED_Alarme !== 1'b0) begin errors++; $display("FAIL alarm_off got %b want 0", bus.LED_Alarme); end
    checks++; if (bus.disp_acionado !== 1'b0) begin errors++; $display("FAIL alarm_disp_early got %b want 0", bus.disp_acionado); end
    step(1, 0, 0, 0);
    checks++; if (bus.disp_acionado !== 1'b1) begin errors++; $display("FAIL alarm_disp_start got %b want 1", bus.disp_acionado); end
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
    checks++; if (bus.contagem !== 5'd6) begin errors++; $display("FAIL alarm_refill_contagem got %0d want 6", bus.contagem); end
    checks++; if (bus.estoque !== 4'd0) begin errors++; $display("FAIL alarm_refill_estoque got %0d want 0", bus.estoque); end
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    checks++; if (bus.LED_Alarme !== 1'b0) begin errors++; $display("FAIL alarm_stays_off got %b want 0", bus.LED_Alarme); end
  endtask

  task automatic test_simultaneous();
    step(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < 12; i++) step(0, 0, 1, 0);
    for (int i = 0; i < 7; i++) step(0, 1, 0, 0);
    checks++; if (bus.contagem !== 5'd5 || bus.estoque !== 4'd15) begin errors++; $display("FAIL simul_setup got %0d/%0d want 5/15", bus.contagem, bus.estoque); end
    step(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    checks++; if (bus.disp_acionado !== 1'b1) begin errors++; $display("FAIL simul_no_abort got %b want 1", bus.disp_acionado); end
    step(0, 1, 1, 0);
    checks++; if (bus.contagem !== 5'd16) begin errors++; $display("FAIL simul_contagem got %0d want 16", bus.contagem); end
    checks++; if (bus.estoque !== 4'd4) begin errors++; $display("FAIL simul_estoque got %0d want 4", bus.estoque); end
    checks++; if (bus.disp_acionado !== 1'b0) begin errors++; $display("FAIL simul_disp got %b want 0", bus.disp_acionado); end
  endtask

  task automatic test_boundaries();
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    checks++; if (bus.contagem !== 5'd0) begin errors++; $display("FAIL bound_dec_contagem got %0d want 0", bus.contagem); end
    checks++; if (bus.erro_dec !== 1'b1) begin errors++; $display("FAIL bound_erro_pulse got %b want 1", bus.erro_dec); end
    step(0, 0, 0, 0);
    checks++; if (bus.erro_dec !== 1'b0) begin errors++; $display("FAIL bound_erro_width got %b want 0", bus.erro_dec); end
    step(0, 0, 1, 0);
    checks++; if (bus.estoque !== 4'd15) begin errors++; $display("FAIL bound_add_sat got %0d want 15", bus.estoque); end
  endtask

  task automatic test_reset_midrefill();
    step(0, 0, 0, 1);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    checks++; if (bus.disp_acionado !== 1'b1) begin errors++; $display("FAIL midrst_pre_disp got %b want 1", bus.disp_acionado); end
    step(1, 0, 0, 1);
    checks++; if (bus.disp_acionado !== 1'b0 || bus.contagem !== 5'd0 || bus.estoque !== 4'd15) begin
      errors++; $display("FAIL midrst_state got disp=%b cont=%0d est=%0d want 0/0/15", bus.disp_acionado, bus.contagem, bus.estoque);
    end
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 0);
      checks++; if (bus.disp_acionado !== 1'b0 || bus.contagem !== 5'd0 || bus.estoque !== 4'd15) begin
        errors++; $display("FAIL midrst_no_transfer cyc=%0d got disp=%b cont=%0d est=%0d want 0/0/15", i, bus.disp_acionado, bus.contagem, bus.estoque);
      end
    end
  endtask

  task automatic test_random();
    bit en, d, a, r;
    step(0, 0, 0, 1);
    for (int i = 0; i < 600; i++) begin
      en = ($urandom_range(0, 3) != 0);
      d  = ($urandom_range(0, 2) == 0);
      a  = ($urandom_range(0, 3) == 0);
      r  = ($urandom_range(0, 149) == 0);
      step(en, d, a, r);
      checks++;
      if (bus.contagem !== 5'(m_mag) || bus.estoque !== 4'(m_stk) ||
          bus.disp_acionado !== (m_busy > 0) || bus.LED_Alarme !== m_alarm ||
          bus.erro_dec !== m_err || bus.rolha_disponivel !== (m_mag != 0)) begin
        errors++;
        $display("FAIL random cyc=%0d got cont=%0d est=%0d disp=%b led=%b err=%b rolha=%b want cont=%0d est=%0d disp=%b led=%b err=%b rolha=%b",
                 i, bus.contagem, bus.estoque, bus.disp_acionado, bus.LED_Alarme, bus.erro_dec, bus.rolha_disponivel,
                 m_mag, m_stk, (m_busy > 0), m_alarm, m_err, (m_mag != 0));
      end
    end
  endtask

  initial begin
    bus.enable     = 1'b0;
    bus.dec        = 1'b0;
    bus.add_manual = 1'b0;
    reset          = 1'b1;
    test_reset();
    test_first_refill();
    test_partial_refill();
    test_alarm();
    test_simultaneous();
    test_boundaries();
    test_reset_midrefill();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
